// File: rtl/trace_dispatch.sv
// Trace-record dispatcher: routes each accepted trace command to the instruction
// cache, data cache, both, or a three-step print sequence; counts unsupported codes.
module trace_dispatch #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_n,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              ic_req,
  output logic [3:0]        ic_n,
  output logic [ADDR_W-1:0] ic_addr,
  input  logic              ic_done,
  output logic              dc_req,
  output logic [3:0]        dc_n,
  output logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_done,
  output logic              stats_print,
  output logic              busy,
  output logic [CNT_W-1:0]  bad_cmd_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    PRINT_I,
    PRINT_D,
    PRINT_S
  } state_t;

  state_t              state, state_nx;
  logic                ic_pend, dc_pend;
  logic                ic_pend_nx, dc_pend_nx;
  logic [3:0]          lat_n;
  logic [ADDR_W-1:0]   lat_addr;
  logic                accept;
  logic                route_ic, route_dc, route_print, route_bad;

  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    route_ic    = 1'b0;
    route_dc    = 1'b0;
    route_print = 1'b0;
    route_bad   = 1'b0;
    case (cmd_n)
      4'd0, 4'd1:       route_dc    = 1'b1;
      4'd2:             route_ic    = 1'b1;
      4'd3, 4'd4, 4'd8: begin
        route_ic = 1'b1;
        route_dc = 1'b1;
      end
      4'd9:             route_print = 1'b1;
      default:          route_bad   = 1'b1;
    endcase
  end

  // Pending flags are the req outputs; each clears only on its own done while set.
  always_comb begin
    state_nx   = state;
    ic_pend_nx = ic_pend;
    dc_pend_nx = dc_pend;
    case (state)
      IDLE: begin
        if (accept) begin
          if (route_print) begin
            state_nx   = PRINT_I;
            ic_pend_nx = 1'b1;
          end else if (route_ic || route_dc) begin
            state_nx   = WAIT;
            ic_pend_nx = route_ic;
            dc_pend_nx = route_dc;
          end
        end
      end
      WAIT: begin
        ic_pend_nx = ic_pend && !ic_done;
        dc_pend_nx = dc_pend && !dc_done;
        if (!ic_pend_nx && !dc_pend_nx) state_nx = IDLE;
      end
      PRINT_I: begin
        if (ic_done) begin
          ic_pend_nx = 1'b0;
          dc_pend_nx = 1'b1;
          state_nx   = PRINT_D;
        end
      end
      PRINT_D: begin
        if (dc_done) begin
          dc_pend_nx = 1'b0;
          state_nx   = PRINT_S;
        end
      end
      PRINT_S: state_nx = IDLE;
      default: begin
        state_nx   = IDLE;
        ic_pend_nx = 1'b0;
        dc_pend_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ic_pend     <= 1'b0;
      dc_pend     <= 1'b0;
      lat_n       <= '0;
      lat_addr    <= '0;
      bad_cmd_cnt <= '0;
    end else begin
      state   <= state_nx;
      ic_pend <= ic_pend_nx;
      dc_pend <= dc_pend_nx;
      if (accept) begin
        lat_n    <= cmd_n;
        lat_addr <= cmd_addr;
      end
      if (accept && route_bad && (bad_cmd_cnt != '1))
        bad_cmd_cnt <= bad_cmd_cnt + 1'b1;
    end
  end

  assign ic_req      = ic_pend;
  assign dc_req      = dc_pend;
  assign ic_n        = ic_pend ? lat_n    : '0;
  assign ic_addr     = ic_pend ? lat_addr : '0;
  assign dc_n        = dc_pend ? lat_n    : '0;
  assign dc_addr     = dc_pend ? lat_addr : '0;
  assign stats_print = (state == PRINT_S);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_trace_dispatch.sv
// Scoreboard bench for trace_dispatch: a job-queue reference model predicts every
// cycle's outputs; a monitor compares them on the falling edge.
module tb_trace_dispatch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cmd_valid, ic_done, dc_done;
  logic [3:0]  cmd_n;
  logic [31:0] cmd_addr;

  logic        cmd_ready, ic_req, dc_req, stats_print, busy;
  logic [3:0]  ic_n, dc_n;
  logic [31:0] ic_addr, dc_addr;
  logic [15:0] bad_cmd_cnt;

  logic        s_cmd_ready, s_ic_req, s_dc_req, s_stats_print, s_busy;
  logic [3:0]  s_ic_n, s_dc_n;
  logic [31:0] s_ic_addr, s_dc_addr;
  logic [3:0]  s_bad_cmd_cnt;

  trace_dispatch #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_n(cmd_n), .cmd_addr(cmd_addr),
    .ic_req(ic_req), .ic_n(ic_n), .ic_addr(ic_addr), .ic_done(ic_done),
    .dc_req(dc_req), .dc_n(dc_n), .dc_addr(dc_addr), .dc_done(dc_done),
    .stats_print(stats_print), .busy(busy), .bad_cmd_cnt(bad_cmd_cnt)
  );

  // Narrow counter copy so saturation is reachable in a few cycles.
  trace_dispatch #(.ADDR_W(32), .CNT_W(4)) sat_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_n(cmd_n), .cmd_addr(cmd_addr),
    .ic_req(s_ic_req), .ic_n(s_ic_n), .ic_addr(s_ic_addr), .ic_done(ic_done),
    .dc_req(s_dc_req), .dc_n(s_dc_n), .dc_addr(s_dc_addr), .dc_done(dc_done),
    .stats_print(s_stats_print), .busy(s_busy), .bad_cmd_cnt(s_bad_cmd_cnt)
  );

  typedef struct packed {
    logic        cmd_ready;
    logic        busy;
    logic        ic_req;
    logic [3:0]  ic_n;
    logic [31:0] ic_addr;
    logic        dc_req;
    logic [3:0]  dc_n;
    logic [31:0] dc_addr;
    logic        stats_print;
    logic [15:0] cnt;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t m;
    obs_t s;
  } sb_item_t;

  typedef struct {
    bit          ic;
    bit          dc;
    bit          st;
    logic [3:0]  n;
    logic [31:0] a;
  } job_t;

  sb_item_t    sb[$];
  job_t        jobs[$];
  int unsigned m_cnt = 0;
  int          cyc_no = 0;
  int          compared = 0;
  int          mismatched = 0;

  function automatic obs_t expect_obs(input bit rst_now, input int unsigned sat);
    obs_t e;
    job_t j;
    e = '0;
    e.cmd_ready = !rst_now && (jobs.size() == 0);
    e.busy      = (jobs.size() != 0);
    if (jobs.size() != 0) begin
      j = jobs[0];
      e.ic_req      = j.ic;
      e.ic_n        = j.ic ? j.n : 4'h0;
      e.ic_addr     = j.ic ? j.a : 32'h0;
      e.dc_req      = j.dc;
      e.dc_n        = j.dc ? j.n : 4'h0;
      e.dc_addr     = j.dc ? j.a : 32'h0;
      e.stats_print = j.st;
    end
    e.cnt = 16'((m_cnt > sat) ? sat : m_cnt);
    return e;
  endfunction

  task automatic step_model(input bit v, input logic [3:0] n, input logic [31:0] a,
                            input bit icd, input bit dcd, input bit r);
    job_t j;
    if (r) begin
      jobs.delete();
      m_cnt = 0;
    end else if (jobs.size() == 0) begin
      if (v) begin
        case (n)
          4'd0, 4'd1:       jobs.push_back('{ic: 1'b0, dc: 1'b1, st: 1'b0, n: n, a: a});
          4'd2:             jobs.push_back('{ic: 1'b1, dc: 1'b0, st: 1'b0, n: n, a: a});
          4'd3, 4'd4, 4'd8: jobs.push_back('{ic: 1'b1, dc: 1'b1, st: 1'b0, n: n, a: a});
          4'd9: begin
            jobs.push_back('{ic: 1'b1, dc: 1'b0, st: 1'b0, n: 4'd9, a: a});
            jobs.push_back('{ic: 1'b0, dc: 1'b1, st: 1'b0, n: 4'd9, a: a});
            jobs.push_back('{ic: 1'b0, dc: 1'b0, st: 1'b1, n: 4'd0, a: 32'h0});
          end
          default:          m_cnt++;
        endcase
      end
    end else begin
      j = jobs[0];
      if (j.st) begin
        void'(jobs.pop_front());
      end else begin
        if (j.ic && icd) j.ic = 1'b0;
        if (j.dc && dcd) j.dc = 1'b0;
        if (!j.ic && !j.dc) void'(jobs.pop_front());
        else jobs[0] = j;
      end
    end
  endtask

  task automatic cycle(input bit v, input logic [3:0] n, input logic [31:0] a,
                       input bit icd, input bit dcd, input bit r);
    sb_item_t it;
    @(posedge clk);
    #1;
    cmd_valid = v;
    cmd_n     = n;
    cmd_addr  = a;
    ic_done   = icd;
    dc_done   = dcd;
    rst       = r;
    it.cyc = cyc_no;
    it.m   = expect_obs(r, 32'd65535);
    it.s   = expect_obs(r, 32'd15);
    sb.push_back(it);
    step_model(v, n, a, icd, dcd, r);
    cyc_no++;
  endtask

  task automatic idle(input bit icd, input bit dcd);
    cycle(1'b0, 4'h0, 32'h0, icd, dcd, 1'b0);
  endtask

  initial begin : monitor
    sb_item_t it;
    obs_t     gm, gs;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        it = sb.pop_front();
        gm = '{cmd_ready, busy, ic_req, ic_n, ic_addr, dc_req, dc_n, dc_addr,
               stats_print, bad_cmd_cnt};
        gs = '{s_cmd_ready, s_busy, s_ic_req, s_ic_n, s_ic_addr, s_dc_req, s_dc_n,
               s_dc_addr, s_stats_print, {12'h0, s_bad_cmd_cnt}};
        compared++;
        if (gm !== it.m) begin
          mismatched++;
          $display("FAIL main_outputs cyc %0d got %h expected %h", it.cyc, gm, it.m);
        end
        compared++;
        if (gs !== it.s) begin
          mismatched++;
          $display("FAIL sat_outputs cyc %0d got %h expected %h", it.cyc, gs, it.s);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int budget;
    rst = 1'b1; cmd_valid = 1'b0; cmd_n = '0; cmd_addr = '0; ic_done = 1'b0; dc_done = 1'b0;
    repeat (2) @(posedge clk);
    cycle(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b0);

    // data-cache only, done three cycles after acceptance
    cycle(1'b1, 4'd0, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0); idle(1'b0, 1'b0); idle(1'b0, 1'b1); idle(1'b0, 1'b0);

    // dual-cache, dones in different cycles
    cycle(1'b1, 4'd3, 32'hABCD_0000, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0); idle(1'b1, 1'b0); idle(1'b0, 1'b0); idle(1'b0, 1'b0);
    idle(1'b0, 1'b1); idle(1'b0, 1'b0);

    // dual-cache, both dones in the first req cycle
    cycle(1'b1, 4'd4, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b1); idle(1'b0, 1'b0);

    // print sequence
    cycle(1'b1, 4'd9, 32'h0000_0090, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0); idle(1'b1, 1'b0); idle(1'b0, 1'b0); idle(1'b0, 1'b1);
    idle(1'b0, 1'b0); idle(1'b0, 1'b0);

    // back-to-back unsupported codes, stray dones while idle
    cycle(1'b1, 4'd6, 32'h1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'd7, 32'h2, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 4'd15, 32'h3, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 1'b1); idle(1'b0, 1'b0);

    // saturation on the narrow-counter instance
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'd5, 32'(i), 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);

    // reset mid-operation, late done ignored
    cycle(1'b1, 4'd8, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    cycle(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(1'b1, 1'b0); idle(1'b0, 1'b1); idle(1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom), 32'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 299) == 0));
    end
    idle(1'b0, 1'b0);

    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (sb.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
